// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux select through ch0..ch3, dwelling DWELL cycles each,
// and assembles the four sampled mux outputs into a 4-bit word with a one-cycle valid.
module mux_scan_sequencer #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] data,
  output logic       valid,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [7:0] LAST = 8'(DWELL - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_shadow;
  logic [1:0] r_sel;
  logic [3:0] r_data;
  logic       r_valid;
  logic       r_busy;
  logic       w_last;
  assign w_last = r_cnt == LAST;
  assign sel    = r_sel;
  assign data   = r_data;
  assign valid  = r_valid;
  assign busy   = r_busy;
  // Channels arrive in order 0,1,2, so shifting in from the top leaves shadow = {ch2,ch1,ch0}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_sel    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= SCAN;
          r_sel   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        SCAN: if (w_last) begin
          r_cnt <= '0;
          if (r_sel == 2'd3) begin
            r_data  <= {mux_out, r_shadow};
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_shadow <= {mux_out, r_shadow[2:1]};
            r_sel    <= r_sel + 2'd1;
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        DONE: begin
          r_valid <= 1'b0;
          r_sel   <= '0;
          r_cnt   <= '0;
          r_state <= continuous ? SCAN : IDLE;
          r_busy  <= continuous;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: scoreboard bench for DWELL=2 and DWELL=1 instances, each feeding
// a combinational model mux (mux_out = i[sel]).
module tb_mux_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start2 = 1'b0, cont2 = 1'b0;
  logic [3:0] i2 = '0;
  logic       mux2;
  logic [1:0] sel2;
  logic [3:0] data2;
  logic       valid2, busy2;
  logic       start1 = 1'b0, cont1 = 1'b0;
  logic [3:0] i1 = '0;
  logic       mux1;
  logic [1:0] sel1;
  logic [3:0] data1;
  logic       valid1, busy1;
  logic [3:0] q2[$];
  logic [3:0] q1[$];
  logic [3:0] exp_d;
  logic [3:0] pats[3];
  int         errors = 0;
  int         checks = 0;
  int         nv;
  int         t1;
  logic       got;

  always #5 clk = ~clk;
  assign mux2 = i2[sel2];
  assign mux1 = i1[sel1];

  mux_scan_sequencer #(.DWELL(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .continuous(cont2), .mux_out(mux2),
    .sel(sel2), .data(data2), .valid(valid2), .busy(busy2)
  );
  mux_scan_sequencer #(.DWELL(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .continuous(cont1), .mux_out(mux1),
    .sel(sel1), .data(data1), .valid(valid1), .busy(busy1)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sel2, data2, valid2, busy2} !== 8'h00) begin
      errors++;
      $display("FAIL reset_d2 sel=%0d data=%b valid=%b busy=%b exp all 0", sel2, data2, valid2, busy2);
    end
    checks++;
    if ({sel1, data1, valid1, busy1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_d1 sel=%0d data=%b valid=%b busy=%b exp all 0", sel1, data1, valid1, busy1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_scan;
    i2 = 4'b1010;
    start2 = 1'b1;
    q2.push_back(i2);
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sel2 !== 2'(k / 2) || valid2 !== 1'b0 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL single_seq cyc=%0d sel=%0d valid=%b busy=%b exp sel=%0d valid=0 busy=1", k, sel2, valid2, busy2, k / 2);
      end
      @(negedge clk);
    end
    checks++;
    if (valid2 !== 1'b1) begin
      errors++;
      $display("FAIL single_valid got=%b exp=1", valid2);
    end else begin
      exp_d = q2.pop_front();
      checks++;
      if (data2 !== exp_d) begin
        errors++;
        $display("FAIL single_data got=%b exp=%b", data2, exp_d);
      end
    end
    @(negedge clk);
    checks++;
    if (valid2 !== 1'b0 || busy2 !== 1'b0 || sel2 !== 2'd0) begin
      errors++;
      $display("FAIL single_after valid=%b busy=%b sel=%0d exp 0 0 0", valid2, busy2, sel2);
    end
  endtask

  task automatic test_dwell1;
    for (int v = 0; v < 16; v++) begin
      i1 = 4'(v);
      start1 = 1'b1;
      q1.push_back(4'(v));
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (sel1 !== 2'(k) || valid1 !== 1'b0) begin
          errors++;
          $display("FAIL d1_seq v=%0d cyc=%0d sel=%0d valid=%b exp sel=%0d valid=0", v, k, sel1, valid1, k);
        end
        @(negedge clk);
      end
      checks++;
      if (valid1 !== 1'b1) begin
        errors++;
        $display("FAIL d1_valid v=%0d got=%b exp=1", v, valid1);
      end else begin
        exp_d = q1.pop_front();
        checks++;
        if (data1 !== exp_d) begin
          errors++;
          $display("FAIL d1_data got=%b exp=%b", data1, exp_d);
        end
      end
      @(negedge clk);
      checks++;
      if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL d1_after v=%0d valid=%b busy=%b exp 0 0", v, valid1, busy1);
      end
    end
    q1.delete();
  endtask

  task automatic test_start_while_busy;
    i2 = 4'b0111;
    start2 = 1'b1;
    q2.push_back(i2);
    @(negedge clk);
    start2 = 1'b0;
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      start2 = (k == 3);
      checks++;
      if (sel2 !== 2'(k / 2)) begin
        errors++;
        $display("FAIL busy_seq cyc=%0d sel=%0d exp=%0d", k, sel2, k / 2);
      end
      @(negedge clk);
    end
    start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (valid2 === 1'b1) begin
        nv++;
        exp_d = q2.pop_front();
        checks++;
        if (data2 !== exp_d) begin
          errors++;
          $display("FAIL busy_data got=%b exp=%b", data2, exp_d);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nv != 1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL busy_valids got=%0d busy=%b exp 1 valid and busy=0", nv, busy2);
    end
  endtask

  task automatic test_continuous;
    cont2 = 1'b1;
    i2 = 4'b0110;
    start2 = 1'b1;
    q2.push_back(i2);
    @(negedge clk);
    start2 = 1'b0;
    nv = 0;
    t1 = 0;
    for (int c = 0; c < 40 && nv < 2; c++) begin
      checks++;
      if (busy2 !== 1'b1) begin
        errors++;
        $display("FAIL cont_busy cyc=%0d got=%b exp=1", c, busy2);
      end
      if (valid2 === 1'b1) begin
        nv++;
        exp_d = q2.pop_front();
        checks++;
        if (data2 !== exp_d) begin
          errors++;
          $display("FAIL cont_data n=%0d got=%b exp=%b", nv, data2, exp_d);
        end
        if (nv == 1) begin
          t1 = c;
          i2 = 4'b1001;
          q2.push_back(i2);
        end else begin
          checks++;
          if (c - t1 != 9) begin
            errors++;
            $display("FAIL cont_period got=%0d exp=9", c - t1);
          end
          cont2 = 1'b0;
        end
      end
      if (nv < 2) @(negedge clk);
    end
    checks++;
    if (nv != 2) begin
      errors++;
      $display("FAIL cont_timeout valids=%0d exp=2", nv);
    end
    cont2 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop busy=%b exp=0", busy2);
    end
  endtask

  task automatic test_async_reset;
    i2 = 4'b1011;
    start2 = 1'b1;
    q2.push_back(i2);
    @(negedge clk);
    start2 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      if (sel2 === 2'd2) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL arst_reach_sel2 sel=%0d exp=2", sel2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sel2, data2, valid2, busy2} !== 8'h00) begin
      errors++;
      $display("FAIL arst_immediate sel=%0d data=%b valid=%b busy=%b exp all 0", sel2, data2, valid2, busy2);
    end
    q2.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    i2 = 4'b0101;
    start2 = 1'b1;
    q2.push_back(i2);
    @(negedge clk);
    start2 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 15 && !got; c++) begin
      if (valid2 === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL arst_rescan_timeout valid=%b exp=1", valid2);
    end else begin
      exp_d = q2.pop_front();
      checks++;
      if (data2 !== exp_d) begin
        errors++;
        $display("FAIL arst_rescan_data got=%b exp=%b", data2, exp_d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_held;
    pats = '{4'b0011, 4'b1100, 4'b0101};
    i2 = pats[0];
    start2 = 1'b1;
    q2.push_back(i2);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      got = 1'b0;
      for (int c = 0; c < 15 && !got; c++) begin
        if (valid2 === 1'b1) got = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL held_timeout scan=%0d valid=%b exp=1", s, valid2);
      end else begin
        exp_d = q2.pop_front();
        checks++;
        if (data2 !== exp_d) begin
          errors++;
          $display("FAIL held_data scan=%0d got=%b exp=%b", s, data2, exp_d);
        end
      end
      @(negedge clk);
      checks++;
      if (busy2 !== 1'b0 || valid2 !== 1'b0) begin
        errors++;
        $display("FAIL held_idle scan=%0d busy=%b valid=%b exp 0 0", s, busy2, valid2);
      end
      if (s < 2) begin
        i2 = pats[s + 1];
        q2.push_back(i2);
      end else begin
        start2 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (busy2 !== (s < 2)) begin
        errors++;
        $display("FAIL held_restart scan=%0d busy=%b exp=%b", s, busy2, s < 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_dwell1();
    test_start_while_busy();
    test_continuous();
    test_async_reset();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
